md_unit: RTL and testbench

//  Multiply/divide unit of the 5-stage MIPS pipeline, driven from E stage. Holds HI/LO, runs

---
 rtl/md_unit_pkg.sv | 61 ++++++
 rtl/md_unit.sv | 151 +++++++++++++++
 tb/tb_md_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/md_unit_pkg.sv
// Shared md-unit definitions: 4-bit md_op encodings (also used by the decoder),
// FSM state type and the multiply/divide arithmetic helpers.
package md_unit_pkg;

    localparam logic [3:0] MD_NONE  = 4'd0;
    localparam logic [3:0] MD_MULT  = 4'd1;
    localparam logic [3:0] MD_MULTU = 4'd2;
    localparam logic [3:0] MD_DIV   = 4'd3;
    localparam logic [3:0] MD_DIVU  = 4'd4;
    localparam logic [3:0] MD_MSUB  = 4'd5;
    localparam logic [3:0] MD_MSUBU = 4'd6;
    localparam logic [3:0] MD_MTHI  = 4'd7;
    localparam logic [3:0] MD_MTLO  = 4'd8;
    localparam logic [3:0] MD_MFHI  = 4'd9;
    localparam logic [3:0] MD_MFLO  = 4'd10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } md_state_e;

    // Full 64-bit product; sign extension first so the low 64 bits are exact.
    function automatic logic [63:0] md_mul(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic [63:0] ea;
        logic [63:0] eb;
        ea = {{32{sgn & a[31]}}, a};
        eb = {{32{sgn & b[31]}}, b};
        return ea * eb;
    endfunction

    // Returns {remainder, quotient}. Signed mode divides magnitudes and then
    // fixes signs, which gives truncation toward zero and makes
    // 0x80000000 / -1 fall out as quotient 0x80000000, remainder 0.
    function automatic logic [63:0] md_div(input logic [31:0] a, input logic [31:0] b,
                                           input logic sgn);
        logic        na;
        logic        nb;
        logic [31:0] ma;
        logic [31:0] mb;
        logic [31:0] q;
        logic [31:0] r;
        na = sgn & a[31];
        nb = sgn & b[31];
        ma = na ? (32'd0 - a) : a;
        mb = nb ? (32'd0 - b) : b;
        if (mb == 32'd0) begin
            mb = 32'd1;
        end
        q = ma / mb;
        r = ma % mb;
        if (na ^ nb) begin
            q = 32'd0 - q;
        end
        if (na) begin
            r = 32'd0 - r;
        end
        return {r, q};
    endfunction

endpackage

// File: rtl/md_unit.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs fixed-latency md ops.
// Optional macro MD_FLUSH_EN adds a flush port that cancels an in-flight op.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | cnt==0, busy low; accepts md ops and mthi/mtlo
// ST_RUN  | cnt!=0, busy high; result held in res_hi/res_lo until cnt==1
module md_unit
    import md_unit_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  md_op,
    input  logic [31:0] rs_d,
    input  logic [31:0] rt_d,
`ifdef MD_FLUSH_EN
    input  logic        flush,
`endif
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO  = '0;

    md_state_e        state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [31:0]      hi_n, lo_n;
    logic [31:0]      res_hi, res_hi_n;
    logic [31:0]      res_lo, res_lo_n;
    logic             res_wr, res_wr_n;
    logic             kill;

    logic [63:0]      acc;
    logic [63:0]      mul_s, mul_u;
    logic [63:0]      div_s, div_u;
    logic             div_zero;

`ifdef MD_FLUSH_EN
    assign kill = flush;
`else
    assign kill = 1'b0;
`endif

    assign acc      = {hi, lo};
    assign mul_s    = md_mul(rs_d, rt_d, 1'b1);
    assign mul_u    = md_mul(rs_d, rt_d, 1'b0);
    assign div_s    = md_div(rs_d, rt_d, 1'b1);
    assign div_u    = md_div(rs_d, rt_d, 1'b0);
    assign div_zero = (rt_d == 32'd0);

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= ST_IDLE;
            cnt    <= CNT_ZERO;
            hi     <= 32'd0;
            lo     <= 32'd0;
            res_hi <= 32'd0;
            res_lo <= 32'd0;
            res_wr <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            hi     <= hi_n;
            lo     <= lo_n;
            res_hi <= res_hi_n;
            res_lo <= res_lo_n;
            res_wr <= res_wr_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        hi_n     = hi;
        lo_n     = lo;
        res_hi_n = res_hi;
        res_lo_n = res_lo;
        res_wr_n = res_wr;
        if (kill) begin
            // Flush wins over both a same-cycle start and completion.
            state_n  = ST_IDLE;
            cnt_n    = CNT_ZERO;
            res_hi_n = 32'd0;
            res_lo_n = 32'd0;
            res_wr_n = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        case (md_op)
                            MD_MULT, MD_MULTU, MD_MSUB, MD_MSUBU: begin
                                case (md_op)
                                    MD_MULT:  {res_hi_n, res_lo_n} = mul_s;
                                    MD_MULTU: {res_hi_n, res_lo_n} = mul_u;
                                    MD_MSUB:  {res_hi_n, res_lo_n} = acc - mul_s;
                                    default:  {res_hi_n, res_lo_n} = acc - mul_u;
                                endcase
                                res_wr_n = 1'b1;
                                cnt_n    = MULT_LOAD;
                                state_n  = ST_RUN;
                            end
                            MD_DIV, MD_DIVU: begin
                                {res_hi_n, res_lo_n} = (md_op == MD_DIV) ? div_s : div_u;
                                // Divide by zero still occupies the unit but never commits.
                                res_wr_n = !div_zero;
                                cnt_n    = DIV_LOAD;
                                state_n  = ST_RUN;
                            end
                            MD_MTHI: hi_n = rs_d;
                            MD_MTLO: lo_n = rs_d;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_ONE) begin
                        if (res_wr) begin
                            hi_n = res_hi;
                            lo_n = res_lo;
                        end
                        res_wr_n = 1'b0;
                        cnt_n    = CNT_ZERO;
                        state_n  = ST_IDLE;
                    end else begin
                        cnt_n = cnt - CNT_ONE;
                    end
                end
                default: begin
                    state_n = ST_IDLE;
                    cnt_n   = CNT_ZERO;
                end
            endcase
        end
    end

    assign busy   = (state == ST_RUN);
    assign md_out = (md_op == MD_MFHI) ? hi :
                    (md_op == MD_MFLO) ? lo : 32'd0;

endmodule

// File: tb/tb_md_unit.sv
// Directed bench for md_unit: reference model pushes expected HI/LO to a
// scoreboard queue at issue, popped and compared when busy drops.
module tb_md_unit;
    import md_unit_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  md_op;
    logic [31:0] rs_d;
    logic [31:0] rt_d;
`ifdef MD_FLUSH_EN
    logic        flush;
`endif
    logic        busy;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] md_out;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    exp_t        sb[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .md_op  (md_op),
        .rs_d   (rs_d),
        .rt_d   (rt_d),
`ifdef MD_FLUSH_EN
        .flush  (flush),
`endif
        .busy   (busy),
        .hi     (hi),
        .lo     (lo),
        .md_out (md_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: independent of the RTL's magnitude-based divider.
    task automatic model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] m;
        int          q;
        int          r;
        exp_t        e;
        m = {m_hi, m_lo};
        case (op)
            MD_MULT:  m = 64'(longint'($signed(a)) * longint'($signed(b)));
            MD_MULTU: m = {32'd0, a} * {32'd0, b};
            MD_MSUB:  m = m - 64'(longint'($signed(a)) * longint'($signed(b)));
            MD_MSUBU: m = m - {32'd0, a} * {32'd0, b};
            MD_DIV: begin
                if (b != 32'd0) begin
                    if (a == 32'h8000_0000 && b == 32'hffff_ffff) begin
                        m = {32'd0, 32'h8000_0000};
                    end else begin
                        q = $signed(a) / $signed(b);
                        r = $signed(a) % $signed(b);
                        m = {32'(r), 32'(q)};
                    end
                end
            end
            MD_DIVU: if (b != 32'd0) m = {a % b, a / b};
            MD_MTHI: m[63:32] = a;
            MD_MTLO: m[31:0] = a;
            default: ;
        endcase
        m_hi = m[63:32];
        m_lo = m[31:0];
        e.hi = m_hi;
        e.lo = m_lo;
        sb.push_back(e);
    endtask

    task automatic pop_cmp(input string tag);
        exp_t e;
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_hi"}, hi, e.hi);
            chk({tag, "_lo"}, lo, e.lo);
        end
    endtask

    // Called at the negedge after the accept edge (plus 'already' busy negedges).
    task automatic finish_op(input string tag, input int n_exp, input int already);
        int cyc;
        cyc = already;
        while (busy === 1'b1 && cyc < 400) begin
            cyc++;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n_exp));
        pop_cmp(tag);
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input int n);
        @(negedge clk);
        model_op(op, a, b);
        md_op = op; rs_d = a; rt_d = b; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        finish_op(tag, n, 0);
    endtask

    task automatic run_mt(input string tag, input logic [3:0] op, input logic [31:0] a);
        @(negedge clk);
        model_op(op, a, 32'd0);
        md_op = op; rs_d = a; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        pop_cmp(tag);
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; md_op = MD_NONE; rs_d = '0; rt_d = '0;
`ifdef MD_FLUSH_EN
        flush = 1'b0;
`endif
        m_hi = '0; m_lo = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_hi", hi, 32'd0);
        chk("rst_lo", lo, 32'd0);
        reset = 1'b1;

        run_op("mult",      MD_MULT,  32'd3,         32'hffff_fffe, MC);
        run_op("multu",     MD_MULTU, 32'hffff_ffff, 32'hffff_ffff, MC);
        run_op("divu",      MD_DIVU,  32'd7,         32'd2,         DC);
        run_op("div_neg",   MD_DIV,   32'hffff_fff9, 32'd2,         DC);
        run_op("div_ovf",   MD_DIV,   32'h8000_0000, 32'hffff_ffff, DC);
        run_op("div_nrem",  MD_DIV,   32'd7,         32'hffff_fffe, DC);
        run_mt("mtlo",      MD_MTLO,  32'd10);
        run_mt("mthi",      MD_MTHI,  32'd0);
        run_op("msub",      MD_MSUB,  32'd2,         32'd3,         MC);
        run_op("msubu",     MD_MSUBU, 32'd1,         32'd5,         MC);

        @(negedge clk);
        md_op = MD_MFHI; #1 chk("mfhi", md_out, m_hi);
        md_op = MD_MFLO; #1 chk("mflo", md_out, m_lo);
        md_op = MD_MULT; #1 chk("md_out_other", md_out, 32'd0);
        md_op = MD_NONE;

        run_mt("mthi_11",   MD_MTHI,  32'h11);
        run_mt("mtlo_22",   MD_MTLO,  32'h22);
        run_op("div_zero",  MD_DIV,   32'd5,         32'd0,         DC);
        run_op("divu_zero", MD_DIVU,  32'd5,         32'd0,         DC);

        // Starts while busy must be dropped; only the mult commits.
        @(negedge clk);
        model_op(MD_MULT, 32'd6, 32'd7);
        md_op = MD_MULT; rs_d = 32'd6; rt_d = 32'd7; start = 1'b1;
        @(negedge clk);
        md_op = MD_MTHI; rs_d = 32'h55;
        @(negedge clk);
        md_op = MD_DIVU; rs_d = 32'd9; rt_d = 32'd3;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        finish_op("mult_busy", MC, 2);
        @(negedge clk);
        chk("post_busy_idle", 32'(busy), 32'd0);

        @(negedge clk);
        md_op = 4'hf; rs_d = 32'h123; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        chk("bad_op_busy", 32'(busy), 32'd0);
        chk("bad_op_hi", hi, m_hi);
        chk("bad_op_lo", lo, m_lo);

        // Reset on the third cycle of a divide: nothing may be written back.
        run_mt("mthi_77", MD_MTHI, 32'h77);
        @(negedge clk);
        md_op = MD_DIV; rs_d = 32'd100; rt_d = 32'd7; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_hi", hi, 32'd0);
        chk("midrst_lo", lo, 32'd0);
        reset = 1'b1;
        m_hi = '0; m_lo = '0;
        repeat (DC + 2) @(negedge clk);
        chk("midrst_late_busy", 32'(busy), 32'd0);
        chk("midrst_late_hi", hi, 32'd0);
        chk("midrst_late_lo", lo, 32'd0);

`ifdef MD_FLUSH_EN
        // Flush on the cnt==1 edge, with a same-cycle mtlo that must be ignored.
        run_mt("mthi_33", MD_MTHI, 32'h33);
        @(negedge clk);
        md_op = MD_MULT; rs_d = 32'd2; rt_d = 32'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0; md_op = MD_NONE;
        repeat (MC - 1) @(negedge clk);
        chk("flush_pre_busy", 32'(busy), 32'd1);
        flush = 1'b1; start = 1'b1; md_op = MD_MTLO; rs_d = 32'h99;
        @(negedge clk);
        flush = 1'b0; start = 1'b0; md_op = MD_NONE;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_hi", hi, m_hi);
        chk("flush_lo", lo, m_lo);
        repeat (3) @(negedge clk);
        chk("flush_late_hi", hi, m_hi);
`endif

        run_op("mult_final", MD_MULT, 32'hffff_fff0, 32'd16, MC);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
